// File: rtl/sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// sync_debounce_bank: per-channel flop synchroniser + stability filter with
// registered rise/fall/any_edge pulses for asynchronous boundary inputs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_debounce_bank #(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               DEBOUNCE = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int               CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];

  logic [WIDTH-1:0] stable_d, stable_q;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;
  logic             any_edge_d, any_edge_q;

  // Plain shift chain: only stage 0 ever sees the asynchronous input.
  always_comb begin
    sync_d[0] = async_in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // A mismatch must be seen on DEBOUNCE consecutive edges before it is taken.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_out[i];
          rise_d[i]   = sync_out[i];
          fall_d[i]   = ~sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    any_edge_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q   <= RST_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      any_edge_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_edge_q <= any_edge_d;
    end
  end

  assign stable_out = stable_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_edge   = any_edge_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce_bank: directed vector table, hand sequences and a random
// run against a window-based reference model, for two parameter sets.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_debounce_bank;

  logic       clk  = 1'b0;
  logic       nr0  = 1'b0;
  logic       nr1  = 1'b0;
  logic [3:0] ain0 = 4'h0;
  logic [3:0] ain1 = 4'h5;

  logic [3:0] sync0, st0, ri0, fa0;
  logic       any0;
  logic [3:0] sync1, st1, ri1, fa1;
  logic       any1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_debounce_bank u_dut0 (
    .clk(clk), .n_rst(nr0), .async_in(ain0), .sync_out(sync0),
    .stable_out(st0), .rise(ri0), .fall(fa0), .any_edge(any0)
  );

  sync_debounce_bank #(
    .WIDTH(4), .STAGES(3), .DEBOUNCE(1), .RST_VAL(4'b0101)
  ) u_dut1 (
    .clk(clk), .n_rst(nr1), .async_in(ain1), .sync_out(sync1),
    .stable_out(st1), .rise(ri1), .fall(fa1), .any_edge(any1)
  );

  // Reference: a delay line of raw samples, and a window of the last
  // filter inputs; a bit flips once the whole window disagrees with it.
  typedef struct packed {
    logic [3:0][3:0] pipe;
    logic [3:0][3:0] hist;
    logic [3:0]      stable;
    logic [3:0]      rise;
    logic [3:0]      fall;
    logic            anye;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t m_reset(input logic [3:0] rv);
    mstate_t n;
    for (int j = 0; j < 4; j++) begin
      n.pipe[j] = rv;
      n.hist[j] = rv;
    end
    n.stable = rv;
    n.rise   = '0;
    n.fall   = '0;
    n.anye   = 1'b0;
    return n;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic [3:0] a,
                                     input int stg, input int db);
    mstate_t    n;
    logic [3:0] sv;
    logic [3:0] chg;
    n  = s;
    sv = s.pipe[stg-1];
    for (int j = 3; j > 0; j--) n.hist[j] = s.hist[j-1];
    n.hist[0] = sv;
    chg = 4'hF;
    for (int j = 0; j < db; j++) chg &= n.hist[j] ^ s.stable;
    n.rise   = chg & sv;
    n.fall   = chg & ~sv;
    n.stable = s.stable ^ chg;
    n.anye   = |chg;
    for (int j = 3; j > 0; j--) n.pipe[j] = s.pipe[j-1];
    n.pipe[0] = a;
    return n;
  endfunction

  always @(posedge clk or negedge nr0) begin
    if (!nr0) m0 <= m_reset(4'h0);
    else      m0 <= m_step(m0, ain0, 2, 4);
  end

  always @(posedge clk or negedge nr1) begin
    if (!nr1) m1 <= m_reset(4'h5);
    else      m1 <= m_step(m1, ain1, 3, 1);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input string tag, input logic [3:0] es,
                          input logic [3:0] est, input logic [3:0] er,
                          input logic [3:0] ef, input logic ea);
    chk({tag, "_sync"},   (k == 0) ? sync0 : sync1, es);
    chk({tag, "_stable"}, (k == 0) ? st0   : st1,   est);
    chk({tag, "_rise"},   (k == 0) ? ri0   : ri1,   er);
    chk({tag, "_fall"},   (k == 0) ? fa0   : fa1,   ef);
    chk({tag, "_any"},    {3'b000, (k == 0) ? any0 : any1}, {3'b000, ea});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [3:0] ain;
    logic [3:0] e_sync;
    logic [3:0] e_stable;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
    logic       e_any;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] a, input logic [3:0] s, input logic [3:0] st,
                     input logic [3:0] r, input logic [3:0] f, input logic e);
    vec_t v;
    v.ain = a; v.e_sync = s; v.e_stable = st; v.e_rise = r; v.e_fall = f; v.e_any = e;
    vecs.push_back(v);
  endtask

  initial begin
    // Step on channel 0: sync after 2 edges, accepted after 6.
    add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    // Two 3-cycle glitches on channel 1, both rejected.
    for (int g = 0; g < 2; g++) begin
      add(4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
      add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
      add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
      add(4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
      add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
      add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    end
    // 0001 -> 1010 at once: simultaneous fall[0], rise[1], rise[3].
    add(4'hA, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) add(4'hA, 4'hA, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'hA, 4'hA, 4'hA, 4'hA, 4'h1, 1'b1);
    add(4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0);

    // Reset hold with inputs differing from the reset value.
    ain0 = 4'hF;
    nr0  = 1'b0;
    nr1  = 1'b0;
    repeat (10) @(negedge clk);
    chk_inst(0, "rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk_inst(1, "rst_var",  4'h5, 4'h5, 4'h0, 4'h0, 1'b0);
    nr0 = 1'b1;
    cyc(5);
    chk_inst(0, "rel_e5", 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    cyc(1);
    chk_inst(0, "rel_e6", 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
    cyc(1);
    chk_inst(0, "rel_e7", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

    // Variant STAGES=3, DEBOUNCE=1: no filter delay.
    nr1 = 1'b1;
    cyc(2);
    chk_inst(1, "var_idle", 4'h5, 4'h5, 4'h0, 4'h0, 1'b0);
    ain1 = 4'h4;
    cyc(3);
    chk_inst(1, "var_e3", 4'h4, 4'h5, 4'h0, 4'h0, 1'b0);
    cyc(1);
    chk_inst(1, "var_e4", 4'h4, 4'h4, 4'h0, 4'h1, 1'b1);
    cyc(1);
    chk_inst(1, "var_e5", 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);

    // Vector table on instance 0 from a clean all-zero state.
    nr0  = 1'b0;
    ain0 = 4'h0;
    cyc(2);
    nr0 = 1'b1;
    cyc(2);
    foreach (vecs[i]) begin
      ain0 = vecs[i].ain;
      cyc(1);
      chk_inst(0, $sformatf("vec%0d", i), vecs[i].e_sync, vecs[i].e_stable,
               vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_any);
    end

    // Reset two cycles into counting on channel 2.
    ain0 = 4'hE;
    cyc(4);
    nr0 = 1'b0;
    #1;
    chk_inst(0, "midrst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    nr0 = 1'b1;
    cyc(5);
    chk_inst(0, "midrst_e5", 4'hE, 4'h0, 4'h0, 4'h0, 1'b0);
    cyc(1);
    chk_inst(0, "midrst_e6", 4'hE, 4'hE, 4'hE, 4'h0, 1'b1);

    // Random run on both instances against the reference model.
    nr1 = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) ain0[b] = ~ain0[b];
        if ($urandom_range(0, 5) == 0) ain1[b] = ~ain1[b];
      end
      nr0 = ($urandom_range(0, 299) != 0);
      nr1 = ($urandom_range(0, 299) != 0);
      cyc(1);
      chk_inst(0, "rnd0", m0.pipe[1], m0.stable, m0.rise, m0.fall, m0.anye);
      chk_inst(1, "rnd1", m1.pipe[2], m1.stable, m1.rise, m1.fall, m1.anye);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_debounce_bank.md
# sync_debounce_bank

Multi-channel input conditioner for asynchronous pins such as buttons, external strobes and handshake lines from other clock domains. Each channel passes through a parametrised-depth flop synchroniser, then a per-channel stability filter. The block produces a raw synchronised value, a debounced value, and single-cycle rise/fall pulses. It sits at the chip boundary and feeds control FSMs that need clean, edge-qualified inputs.

## Interface
- WIDTH, 4: number of independent channels.
- STAGES, 2: synchroniser flops per channel; legal range ≥ 2.
- DEBOUNCE, 4: consecutive cycles a new synchronised value must persist before it is accepted; legal range ≥ 1, where 1 means no filtering.
- RST_VAL, {WIDTH{1'b0}}: per-channel value loaded into all synchroniser stages and into stable_out on reset.
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- async_in  input  WIDTH  unsynchronised channel inputs.
- sync_out  output  WIDTH  last synchroniser stage (raw, unfiltered).
- stable_out  output  WIDTH  debounced channel value.
- rise  output  WIDTH  one-cycle pulse when stable_out goes 0→1.
- fall  output  WIDTH  one-cycle pulse when stable_out goes 1→0.
- any_edge  output  1  registered OR of all rise and fall bits for the same cycle.

## Operation
- Synchroniser, per channel:
  - Stage 1 samples async_in[i] on every rising clk edge.
  - Stage k samples stage k-1.
  - sync_out[i] is stage STAGES.
  - No logic between stages.
- Filter, per channel: counter cnt[i], width $clog2(DEBOUNCE) (minimum 1 bit). Each cycle:
  - sync_out[i] == stable_out[i]: cnt[i] ← 0, no other change.
  - sync_out[i] != stable_out[i] and cnt[i] < DEBOUNCE-1: cnt[i] ← cnt[i]+1.
  - sync_out[i] != stable_out[i] and cnt[i] == DEBOUNCE-1: this is the update case.
    - stable_out[i] ← sync_out[i] and cnt[i] ← 0.
    - rise[i] ← sync_out[i]; fall[i] ← ~sync_out[i].
- rise/fall are registered. They are high only in the cycle in which stable_out[i] shows its new value, and cleared the next cycle.
- cnt never exceeds DEBOUNCE-1. No saturation or wrap is possible.
- Glitch rejection: a mismatch shorter than DEBOUNCE consecutive cycles at sync_out clears the counter with no update and no pulse. Counting restarts from 0 on the next mismatch.
- Channels are fully independent. Simultaneous updates on several channels produce simultaneous pulses. any_edge is a single pulse for that cycle.
- Reset (asynchronous, immediate, valid mid-count):
  - All synchroniser stages, sync_out and stable_out ← RST_VAL.
  - cnt ← 0.
  - rise, fall, any_edge ← 0.
- No edge pulse is generated on reset entry or exit, even if async_in differs from RST_VAL. Such a difference is filtered like any other change after release.

## Timing
- Let async_in[i] change and stay stable before rising edge E1, with E1 the first edge to sample it.
  - sync_out[i] changes after edge E(STAGES).
  - stable_out[i], rise/fall[i] and any_edge change after edge E(STAGES+DEBOUNCE).
- Total input-to-pulse latency: STAGES+DEBOUNCE edges. Default 2+4 = 6.
- Pulse width: exactly 1 clk cycle.
- Minimum spacing between two pulses on the same channel: DEBOUNCE cycles.
- Metastability: only stage 1 may go metastable. All outputs are flop outputs with no combinational path from async_in.

## Test plan
Defaults WIDTH=4, STAGES=2, DEBOUNCE=4, RST_VAL=4'b0000 unless noted.

- **Reset hold:** n_rst=0 with async_in=4'hF for 10 cycles → sync_out=stable_out=0, rise=fall=0, any_edge=0. Release n_rst → stable_out=4'hF after edge 6 with rise=4'hF and any_edge=1 for one cycle.
- **Step and latency:** async_in[0] 0→1 before E1 → sync_out[0]=1 after E2. stable_out[0]=1, rise[0]=1 and any_edge=1 after E6. rise[0]=0 after E7.
- **Glitch rejection:** async_in[1]=1 for exactly 3 cycles → sync_out[1] high for 3 cycles. stable_out[1] stays 0. No rise/fall/any_edge. A second 3-cycle pulse is also rejected, confirming counter clear.
- **Fall and simultaneity:** from stable 4'b0001, apply async_in=4'b1010 at once → fall[0], rise[1], rise[3] all high in the same cycle after E6. any_edge is a single one-cycle pulse.
- **Reset mid-count:** assert n_rst 2 cycles into counting on channel 2 → immediate clear of all outputs. After release with async_in[2] still 1 → full 6-edge latency before rise[2].
- **Parameter variant:** STAGES=3, DEBOUNCE=1, RST_VAL=4'b0101.
  - After reset, stable_out=4'b0101 with no pulses.
  - async_in=4'b0100 → fall[0] after E4, no filtering delay.
